// File: rtl/mac_pkg.sv
// Shared types and constants for the dot-product MAC slice.
package mac_pkg;

  localparam int OP_W      = 4;
  localparam int PROD_W    = 8;
  localparam int LEN_W_DEF = 4;
  localparam int ACC_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/dot_product_accumulator_if.sv
// Burst control, operand stream and result stream
// of the dot-product accumulator.
interface dot_product_accumulator_if #(
  parameter int ACC_W = 12,
  parameter int LEN_W = 4
);

  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       a;
  logic [3:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             overflow;
  logic             busy;

  modport master (
    output start, len,
    output in_valid, a, b,
    input  in_ready,
    input  out_valid, result, overflow,
    output out_ready,
    input  busy
  );

  modport slave (
    input  start, len,
    input  in_valid, a, b,
    output in_ready,
    output out_valid, result, overflow,
    input  out_ready,
    output busy
  );

endinterface

// File: rtl/array_multiplier.sv
// 4x4 unsigned combinational multiplier built from
// AND-gated partial products.
module array_multiplier
  import mac_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < OP_W; i++) begin
      if (b[i]) begin
        p = p + (PROD_W'(a) << i);
      end
    end
  end

endmodule

// File: rtl/dot_product_accumulator.sv
// Burst MAC: registered product feeding a wide
// accumulator, with valid/ready on both sides.
module dot_product_accumulator
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input logic clk,
  input logic rst,
  dot_product_accumulator_if.slave bus
);

  state_t             state;
  logic [LEN_W-1:0]   remaining;
  logic [PROD_W-1:0]  prod_c;
  logic [PROD_W-1:0]  prod_q;
  logic               prod_v;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W:0]     sum;
  logic               hs;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               ovf_q;
  logic               busy_q;

  array_multiplier u_mul (
    .a (bus.a),
    .b (bus.b),
    .p (prod_c)
  );

  assign hs  = bus.in_valid & in_ready_q;
  assign sum = {1'b0, acc} + (ACC_W+1)'(prod_q);

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = acc;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      prod_q      <= '0;
      prod_v      <= 1'b0;
      acc         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            acc    <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (bus.len != '0) begin
              remaining  <= bus.len;
              in_ready_q <= 1'b1;
              state      <= ACCUM;
            end else begin
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
          end
        end
        ACCUM: begin
          prod_v <= hs;
          if (hs) begin
            prod_q    <= prod_c;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) begin
              in_ready_q <= 1'b0;
            end
          end
          if (prod_v) begin
            acc   <= sum[ACC_W-1:0];
            ovf_q <= ovf_q | sum[ACC_W];
          end
          // exit only after the last product has landed in acc
          if (remaining == '0 && !prod_v) begin
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator with
// a 12-bit and an 8-bit accumulator instance.
module tb_dot_product_accumulator;

  logic clk;
  logic rst;

  dot_product_accumulator_if #(.ACC_W(12), .LEN_W(4)) if12 ();
  dot_product_accumulator_if #(.ACC_W(8),  .LEN_W(4)) if8  ();

  dot_product_accumulator #(.ACC_W(12), .LEN_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (if12)
  );

  dot_product_accumulator #(.ACC_W(8), .LEN_W(4)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]        len;
    logic [14:0][3:0]  a;
    logic [14:0][3:0]  b;
    logic              gap;
    logic [11:0]       exp_res;
    logic              exp_ovf;
  } vec_t;

  vec_t vecs [4];
  vec_t v6;
  int   n_checks;
  int   n_fail;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input vec_t v, input string tag);
    int idx;
    int cyc;
    int k;
    logic hs_pend;
    if12.out_ready = 1'b1;
    if12.start = 1'b1;
    if12.len   = v.len;
    tick();
    if12.start = 1'b0;
    check({tag, "_busy"}, if12.busy, 1);
    check({tag, "_in_ready"}, if12.in_ready, 1);
    idx = 0;
    cyc = 0;
    while (idx < int'(v.len) && cyc < 200) begin
      if12.in_valid = v.gap ? (cyc % 2 == 0) : 1'b1;
      if12.a = if12.in_valid ? v.a[idx] : 4'hA;
      if12.b = if12.in_valid ? v.b[idx] : 4'h5;
      hs_pend = if12.in_valid & if12.in_ready;
      tick();
      if (hs_pend) idx++;
      cyc++;
    end
    if12.in_valid = 1'b0;
    check({tag, "_accepts"}, idx, v.len);
    check({tag, "_in_ready_drop"}, if12.in_ready, 0);
    k = 0;
    while (!if12.out_valid && k < 10) begin
      tick();
      k++;
    end
    check({tag, "_latency"}, k, 2);
    check({tag, "_result"}, if12.result, v.exp_res);
    check({tag, "_overflow"}, if12.overflow, v.exp_ovf);
    tick();
    check({tag, "_out_valid_1cyc"}, if12.out_valid, 0);
    check({tag, "_busy_idle"}, if12.busy, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    if12.start = 0; if12.len = 0; if12.in_valid = 0;
    if12.a = 0; if12.b = 0; if12.out_ready = 1;
    if8.start = 0; if8.len = 0; if8.in_valid = 0;
    if8.a = 0; if8.b = 0; if8.out_ready = 1;

    vecs[0] = '0;
    vecs[0].len = 3;
    vecs[0].a[0] = 3;  vecs[0].b[0] = 5;
    vecs[0].a[1] = 15; vecs[0].b[1] = 15;
    vecs[0].a[2] = 0;  vecs[0].b[2] = 9;
    vecs[0].exp_res = 240;
    vecs[1] = '0;
    vecs[1].len = 15;
    vecs[1].gap = 1;
    for (int i = 0; i < 15; i++) begin
      vecs[1].a[i] = 15;
      vecs[1].b[i] = 15;
    end
    vecs[1].exp_res = 3375;
    vecs[2] = '0;
    vecs[2].len = 2;
    vecs[2].a[0] = 1; vecs[2].b[0] = 1;
    vecs[2].a[1] = 2; vecs[2].b[1] = 2;
    vecs[2].exp_res = 5;
    vecs[3] = '0;
    vecs[3].len = 4;
    vecs[3].a[0] = 4;  vecs[3].b[0] = 5;
    vecs[3].a[1] = 6;  vecs[3].b[1] = 7;
    vecs[3].a[2] = 8;  vecs[3].b[2] = 9;
    vecs[3].a[3] = 10; vecs[3].b[3] = 11;
    vecs[3].exp_res = 244;

    tick();
    check("rst_in_ready", if12.in_ready, 0);
    check("rst_out_valid", if12.out_valid, 0);
    check("rst_busy", if12.busy, 0);
    check("rst_result", if12.result, 0);
    check("rst_overflow", if12.overflow, 0);
    check("rst8_result", if8.result, 0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", if12.in_ready, 0);

    for (int t = 0; t < 4; t++) begin
      run_burst(vecs[t], $sformatf("vec%0d", t));
    end

    // 8-bit accumulator wraps and flags overflow
    if8.start = 1; if8.len = 2;
    tick();
    if8.start = 0;
    if8.in_valid = 1; if8.a = 15; if8.b = 15;
    check("w8_in_ready", if8.in_ready, 1);
    tick();
    tick();
    if8.in_valid = 0;
    for (int k = 0; k < 10 && !if8.out_valid; k++) tick();
    check("w8_out_valid", if8.out_valid, 1);
    check("w8_result", if8.result, 194);
    check("w8_overflow", if8.overflow, 1);
    tick();
    check("w8_idle", if8.busy, 0);

    // zero-length burst goes straight to DONE
    if12.start = 1; if12.len = 0;
    tick();
    if12.start = 0;
    check("len0_out_valid", if12.out_valid, 1);
    check("len0_result", if12.result, 0);
    check("len0_in_ready", if12.in_ready, 0);
    check("len0_busy", if12.busy, 1);
    tick();
    check("len0_idle", if12.out_valid, 0);

    // held result under back-pressure, start ignored
    if12.out_ready = 0;
    if12.start = 1; if12.len = 1;
    tick();
    if12.start = 0;
    if12.in_valid = 1; if12.a = 7; if12.b = 9;
    tick();
    if12.in_valid = 0;
    for (int k = 0; k < 10 && !if12.out_valid; k++) tick();
    check("bp_out_valid", if12.out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      if12.start = (c == 2);
      if12.len   = 3;
      tick();
      check($sformatf("bp_result_%0d", c), if12.result, 63);
      check($sformatf("bp_valid_%0d", c), if12.out_valid, 1);
      check($sformatf("bp_busy_%0d", c), if12.busy, 1);
    end
    if12.start = 0;
    if12.out_ready = 1;
    tick();
    check("bp_release_valid", if12.out_valid, 0);
    check("bp_release_busy", if12.busy, 0);
    check("bp_release_in_ready", if12.in_ready, 0);
    check("bp_result_kept", if12.result, 63);

    // asynchronous reset in the middle of a burst
    if12.start = 1; if12.len = 4;
    tick();
    if12.start = 0;
    if12.in_valid = 1; if12.a = 3; if12.b = 3;
    tick();
    tick();
    if12.in_valid = 0;
    check("mid_busy", if12.busy, 1);
    check("mid_acc", if12.result, 9);
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready", if12.in_ready, 0);
    check("arst_busy", if12.busy, 0);
    check("arst_result", if12.result, 0);
    check("arst_out_valid", if12.out_valid, 0);
    check("arst_overflow", if12.overflow, 0);
    tick();
    rst = 1'b0;
    v6 = '0;
    v6.len = 1;
    v6.a[0] = 2; v6.b[0] = 3;
    v6.exp_res = 6;
    run_burst(v6, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
